// File: rtl/multi_issue_ctrl.sv
// Bundle decoder / issue controller: decodes LANES MIPS instructions, issues the largest hazard-free
// prefix per cycle into a registered ID/EX group. Define ISSUE_STATS_EN to add stat_split/stat_bubble.

module mic_lane_dec (
  input  logic [31:0] instr,
  output logic [13:0] ctrl,
  output logic [4:0]  dst,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic        rs_rd,
  output logic        rt_rd
);
  logic [5:0] op, fn;
  logic [3:0] alu;
  logic       rdst, m2r, asrc, rw, mr, mw, br, jmp, jr, jal;
  logic       unused_shamt;

  assign op = instr[31:26];
  assign fn = instr[5:0];
  assign rs = instr[25:21];
  assign rt = instr[20:16];
  assign unused_shamt = ^instr[10:6];

  always_comb begin
    alu = 4'hF; rdst = 1'b0; m2r = 1'b0; asrc = 1'b0; rw = 1'b0;
    mr = 1'b0; mw = 1'b0; br = 1'b0; jmp = 1'b0; jr = 1'b0; jal = 1'b0;
    rs_rd = 1'b1; rt_rd = 1'b0;
    case (op)
      6'h00: begin
        rdst = 1'b1; rt_rd = 1'b1; rw = 1'b1;
        case (fn)
          6'h20: alu = 4'h0;
          6'h22: alu = 4'h1;
          6'h24: alu = 4'h2;
          6'h25: alu = 4'h3;
          6'h26: alu = 4'h5;
          6'h27: alu = 4'h4;
          6'h2A: alu = 4'h6;
          6'h30: alu = 4'h7;
          6'h00: alu = 4'h8;
          6'h02: alu = 4'h9;
          6'h08: begin rw = 1'b0; jr = 1'b1; end
          default: rw = 1'b0;
        endcase
      end
      6'h02: begin jmp = 1'b1; rs_rd = 1'b0; end
      6'h03: begin jmp = 1'b1; jal = 1'b1; rw = 1'b1; rs_rd = 1'b0; end
      6'h04: begin alu = 4'hA; br = 1'b1; rt_rd = 1'b1; end
      6'h05: begin alu = 4'hB; br = 1'b1; rt_rd = 1'b1; end
      6'h08: begin alu = 4'h0; asrc = 1'b1; rw = 1'b1; end
      6'h0A: begin alu = 4'h6; asrc = 1'b1; rw = 1'b1; end
      6'h0C: begin alu = 4'h2; asrc = 1'b1; rw = 1'b1; end
      6'h0D: begin alu = 4'h3; asrc = 1'b1; rw = 1'b1; end
      6'h0E: begin alu = 4'h5; asrc = 1'b1; rw = 1'b1; end
      6'h23: begin alu = 4'h0; asrc = 1'b1; rw = 1'b1; m2r = 1'b1; mr = 1'b1; end
      6'h2B: begin alu = 4'h0; asrc = 1'b1; mw = 1'b1; rt_rd = 1'b1; end
      default: rdst = 1'b1;
    endcase
  end

  assign ctrl = {alu, rdst, m2r, asrc, rw, mr, mw, br, jmp, jr, jal};
  assign dst  = !rw ? 5'd0 : jal ? 5'd31 : rdst ? instr[15:11] : rt;
endmodule

module multi_issue_ctrl #(
  parameter int LANES     = 2,
  parameter int MEM_PORTS = 1,
  localparam int CTRL_W   = 14
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [32*LANES-1:0]       in_instr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES-1:0]          out_lane_valid,
  output logic [CTRL_W*LANES-1:0]   out_ctrl,
  output logic [5*LANES-1:0]        out_dst
`ifdef ISSUE_STATS_EN
  ,
  output logic [15:0]               stat_split,
  output logic [15:0]               stat_bubble
`endif
);
  typedef enum logic [1:0] {RUN, SPLIT, BUBBLE} state_t;

  state_t                        state, ret_state, eff;
  logic [LANES-1:0][31:0]        bund_q, src;
  logic [LANES-1:0][CTRL_W-1:0]  ctrl, ctrl_q;
  logic [LANES-1:0][4:0]         dst, rs, rt, dst_q;
  logic [LANES-1:0]              rs_rd, rt_rd, pend_q, pend, grp, rem;
  logic [4:0]                    trk, lw_dst;
  logic                          trk_vld, lw_hit, lu, adv, go, done;

  // BUBBLE behaves as the state it interrupted; the tracker is already clear so it issues.
  assign eff = (state == BUBBLE) ? ret_state : state;
  assign src = (eff == SPLIT) ? bund_q : in_instr;

  generate
    for (genvar k = 0; k < LANES; k++) begin : g_lane
      mic_lane_dec u_dec (
        .instr (src[k]),
        .ctrl  (ctrl[k]),
        .dst   (dst[k]),
        .rs    (rs[k]),
        .rt    (rt[k]),
        .rs_rd (rs_rd[k]),
        .rt_rd (rt_rd[k])
      );
    end
  endgenerate

  always_comb begin
    logic [31:0] wr;
    int          memc;
    logic        first, stop, brk, mem;
    pend   = (eff == SPLIT) ? pend_q : '1;
    grp    = '0;
    wr     = '0;
    memc   = 0;
    first  = 1'b1;
    stop   = 1'b0;
    brk    = 1'b0;
    mem    = 1'b0;
    lu     = 1'b0;
    lw_hit = 1'b0;
    lw_dst = '0;
    for (int j = 0; j < LANES; j++) begin
      mem = ctrl[j][5] | ctrl[j][4];
      if (pend[j] && !stop) begin
        if (first)
          lu = trk_vld && (trk != 5'd0) &&
               ((rs_rd[j] && rs[j] == trk) || (rt_rd[j] && rt[j] == trk));
        if (!first && ((rs_rd[j] && wr[rs[j]]) || (rt_rd[j] && wr[rt[j]]) || brk ||
                       (memc + int'(mem) > MEM_PORTS))) begin
          stop = 1'b1;
        end else begin
          grp[j] = 1'b1;
          first  = 1'b0;
          memc   = memc + int'(mem);
          brk    = brk | ctrl[j][3] | ctrl[j][2];
          if (dst[j] != 5'd0) wr[dst[j]] = 1'b1;
          if (ctrl[j][5]) begin lw_hit = 1'b1; lw_dst = dst[j]; end
        end
      end
    end
    rem = pend & ~grp;
  end

  assign done     = (rem == '0);
  assign go       = (eff == SPLIT) || in_valid;
  assign adv      = !out_valid || out_ready;
  assign in_ready = !flush && adv && go && !lu && done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= RUN;
      ret_state      <= RUN;
      pend_q         <= '0;
      bund_q         <= '0;
      trk            <= '0;
      trk_vld        <= 1'b0;
      out_valid      <= 1'b0;
      out_lane_valid <= '0;
      ctrl_q         <= '0;
      dst_q          <= '0;
    end else if (flush) begin
      state          <= RUN;
      pend_q         <= '0;
      trk_vld        <= 1'b0;
      out_valid      <= 1'b0;
      out_lane_valid <= '0;
      ctrl_q         <= '0;
      dst_q          <= '0;
    end else if (adv) begin
      if (!go || lu) begin
        out_valid      <= 1'b0;
        out_lane_valid <= '0;
        ctrl_q         <= '0;
        dst_q          <= '0;
        if (lu) begin
          state     <= BUBBLE;
          ret_state <= eff;
          trk_vld   <= 1'b0;
        end else begin
          state <= RUN;
        end
      end else begin
        out_valid      <= 1'b1;
        out_lane_valid <= grp;
        for (int k = 0; k < LANES; k++) begin
          ctrl_q[k] <= grp[k] ? ctrl[k] : '0;
          dst_q[k]  <= grp[k] ? dst[k]  : '0;
        end
        if (lw_hit) begin
          trk     <= lw_dst;
          trk_vld <= 1'b1;
        end
        pend_q <= rem;
        bund_q <= src;
        state  <= done ? RUN : SPLIT;
      end
    end
  end

  assign out_ctrl = ctrl_q;
  assign out_dst  = dst_q;

`ifdef ISSUE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_split  <= '0;
      stat_bubble <= '0;
    end else if (adv) begin
      if (state == SPLIT && stat_split != 16'hFFFF)   stat_split  <= stat_split + 16'd1;
      if (state == BUBBLE && stat_bubble != 16'hFFFF) stat_bubble <= stat_bubble + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_multi_issue_ctrl.sv
// Directed bench for multi_issue_ctrl (LANES=2, MEM_PORTS=1) with hand-computed control words.
module tb_multi_issue_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [63:0] in_instr;
  logic [1:0]  out_lane_valid;
  logic [27:0] out_ctrl;
  logic [9:0]  out_dst;
`ifdef ISSUE_STATS_EN
  logic [15:0] stat_split, stat_bubble;
`endif
  int n_cmp = 0;
  int n_err = 0;

  multi_issue_ctrl #(.LANES(2), .MEM_PORTS(1)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_instr       (in_instr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_lane_valid (out_lane_valid),
    .out_ctrl       (out_ctrl),
    .out_dst        (out_dst)
`ifdef ISSUE_STATS_EN
    ,
    .stat_split     (stat_split),
    .stat_bubble    (stat_bubble)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] r_op(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rs, rt,
                                       input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic chk_out(input string tag, input logic [1:0] lv, input logic [27:0] c,
                         input logic [9:0] d);
    chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, ".lanes"}, {30'd0, out_lane_valid}, {30'd0, lv});
    chk({tag, ".ctrl"},  {4'd0, out_ctrl}, {4'd0, c});
    chk({tag, ".dst"},   {22'd0, out_dst}, {22'd0, d});
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, ".lanes"}, {30'd0, out_lane_valid}, 32'd0);
    chk({tag, ".ctrl"},  {4'd0, out_ctrl}, 32'd0);
    chk({tag, ".dst"},   {22'd0, out_dst}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_instr = '0;
    #2 rst_n = 1'b0;
    #2 chk_idle("reset");
    tick;
    rst_n = 1'b1;
    tick;

    // ADD $3,$1,$2 | SUB $4,$5,$6 : full dual issue
    in_valid = 1'b1;
    in_instr = {r_op(5, 6, 4, 6'h22), r_op(1, 2, 3, 6'h20)};
    #1 chk("dual.in_ready", {31'd0, in_ready}, 32'd1);
    tick;
    chk_out("dual", 2'b11, {14'h0640, 14'h0240}, {5'd4, 5'd3});

    // ADDI $2,$0,5 | OR $7,$2,$1 : RAW split
    in_instr = {r_op(2, 1, 7, 6'h25), i_op(6'h08, 0, 2, 16'd5)};
    #1 chk("raw.rdy0", {31'd0, in_ready}, 32'd0);
    tick;
    chk_out("raw.g0", 2'b01, {14'h0000, 14'h00C0}, {5'd0, 5'd2});
    chk("raw.rdy1", {31'd0, in_ready}, 32'd1);
    tick;
    chk_out("raw.g1", 2'b10, {14'h0E40, 14'h0000}, {5'd7, 5'd0});

    // LW $8,0($1) | SW $9,4($1) : memory-port split
    in_instr = {i_op(6'h2B, 1, 9, 16'd4), i_op(6'h23, 1, 8, 16'd0)};
    #1 chk("mem.rdy0", {31'd0, in_ready}, 32'd0);
    tick;
    chk_out("mem.g0", 2'b01, {14'h0000, 14'h01E0}, {5'd0, 5'd8});
    chk("mem.rdy1", {31'd0, in_ready}, 32'd1);
    tick;
    chk_out("mem.g1", 2'b10, {14'h0090, 14'h0000}, 10'd0);

    // AND $10,$8,$1 | ADD $11,$1,$2 : load-use bubble on $8
    in_instr = {r_op(1, 2, 11, 6'h20), r_op(8, 1, 10, 6'h24)};
    #1 chk("lu.rdy0", {31'd0, in_ready}, 32'd0);
    tick;
    chk_idle("lu.bubble");
    chk("lu.rdy1", {31'd0, in_ready}, 32'd1);
    tick;
    chk_out("lu.issue", 2'b11, {14'h0240, 14'h0A40}, {5'd11, 5'd10});

    // BEQ $1,$2 | ADD $5,$1,$2 : branch ends group, flush drops ADD
    in_instr = {r_op(1, 2, 5, 6'h20), i_op(6'h04, 1, 2, 16'h0010)};
    #1 chk("br.rdy0", {31'd0, in_ready}, 32'd0);
    tick;
    chk_out("br.g0", 2'b01, {14'h0000, 14'h2808}, 10'd0);
    flush = 1'b1;
    #1 chk("fl.rdy", {31'd0, in_ready}, 32'd0);
    tick;
    flush = 1'b0;
    chk_idle("fl.out");
    // XOR $12,$1,$2 | NOR $13,$3,$4 : both lanes issue only if back in RUN
    in_instr = {r_op(3, 4, 13, 6'h27), r_op(1, 2, 12, 6'h26)};
    #1 chk("fl.rdy1", {31'd0, in_ready}, 32'd1);
    tick;
    chk_out("fl.fresh", 2'b11, {14'h1240, 14'h1640}, {5'd13, 5'd12});

    // JAL | ADD $3,$1,$2 : jump ends group, JAL writes $31
    in_instr = {r_op(1, 2, 3, 6'h20), {6'h03, 26'h0000010}};
    #1 chk("jal.rdy0", {31'd0, in_ready}, 32'd0);
    tick;
    chk_out("jal.g0", 2'b01, {14'h0000, 14'h3C45}, {5'd0, 5'd31});
    tick;
    chk_out("jal.g1", 2'b10, {14'h0240, 14'h0000}, {5'd3, 5'd0});

    // ADD $3,$1,$2 | unknown opcode 3F
    in_instr = {32'hFC00_0000, r_op(1, 2, 3, 6'h20)};
    tick;
    chk_out("unk", 2'b11, {14'h3E00, 14'h0240}, {5'd0, 5'd3});

    // stall in SPLIT, then reset mid-SPLIT
    in_instr = {r_op(2, 1, 7, 6'h25), i_op(6'h08, 0, 2, 16'd5)};
    tick;
    chk_out("stall.g0", 2'b01, {14'h0000, 14'h00C0}, {5'd0, 5'd2});
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("stall.rdy", {31'd0, in_ready}, 32'd0);
      chk_out("stall.hold", 2'b01, {14'h0000, 14'h00C0}, {5'd0, 5'd2});
    end
    rst_n = 1'b0;
    #1 chk_idle("rst.mid");
    #2 rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick;
    chk_idle("rst.after");
    in_valid = 1'b1;
    in_instr = {r_op(5, 6, 4, 6'h22), r_op(1, 2, 3, 6'h20)};
    #1 chk("rst.rdy", {31'd0, in_ready}, 32'd1);
    tick;
    chk_out("rst.fresh", 2'b11, {14'h0640, 14'h0240}, {5'd4, 5'd3});
    in_valid = 1'b0;
    tick;
    chk("idle.valid", {31'd0, out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
